// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } slave_state_e;

    // Lane mask for a transfer starting at byte lane 0; anything wider than a
    // half-word is treated as a full word.
    function automatic logic [3:0] size_mask(input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: size_mask = 4'b0001;
            HSIZE_HALF: size_mask = 4'b0011;
            default:    size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_byte_strobe.sv
// Little-endian byte-lane strobe from transfer size and the low address bits.
// Lanes that would fall past byte 3 (misaligned transfers) are dropped.
module ahb_lite_byte_strobe
    import ahb_lite_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strobe
);

    logic [6:0] shifted;

    // Shift the size mask up to the addressed lane and keep the word's 4 lanes.
    always_comb begin
        shifted = {3'b000, size_mask(hsize)} << addr_lo;
        strobe  = shifted[3:0];
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with a programmable number of wait states per transfer.
// Optional feature: define AHB_SRAM_ERR_EN to answer out-of-range, oversized or
// misaligned transfers with a two-cycle ERROR response instead of completing
// them OKAY with a wrapped index and masked lanes.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    slave_state_e     state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;
    logic             dphase_q, dphase_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       lo_q, lo_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             accept;
    logic             req_err;
    logic [3:0]       strobe;
    logic             wr_en;
    logic             rd_en;
    logic             unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:IDX_W+2]};

    // Address phase is taken only for an active transfer on a ready bus.
    assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_ERR_EN
    logic addr_oob;
    logic bad_size;
    logic misalign;

    // Classify the incoming address phase as one that must be refused.
    always_comb begin
        addr_oob = |HADDR[31:IDX_W+2];
        bad_size = (HSIZE > HSIZE_WORD);
        misalign = ((HSIZE == HSIZE_HALF) & HADDR[0]) |
                   ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]));
        req_err  = addr_oob | bad_size | misalign;
    end
`else
    assign req_err = 1'b0;
`endif

    ahb_lite_byte_strobe u_strobe (
        .hsize   (size_q),
        .addr_lo (lo_q),
        .strobe  (strobe)
    );

    // Data phase completes in the cycle where a pending transfer sees HREADYOUT=1.
    assign wr_en = dphase_q & hreadyout_q & write_q;
    assign rd_en = dphase_q & hreadyout_q & ~write_q;

    // Next-state, wait counter and registered bus responses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        dphase_d    = dphase_q;
        write_d     = write_q;
        size_d      = size_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        unique case (state_q)
            S_IDLE, S_ERR2: begin
                // Completing (or idle) cycle: a new address phase may be taken here.
                state_d     = S_IDLE;
                cnt_d       = 4'd0;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                dphase_d    = 1'b0;
                if (accept) begin
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    idx_d   = HADDR[IDX_W+1:2];
                    lo_d    = HADDR[1:0];
                    if (req_err) begin
                        state_d     = S_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = HRESP_ERROR;
                    end else if (WS != 4'd0) begin
                        state_d     = S_WAIT;
                        cnt_d       = WS;
                        hreadyout_d = 1'b0;
                        dphase_d    = 1'b1;
                    end else begin
                        dphase_d    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d     = S_IDLE;
                    cnt_d       = 4'd0;
                    hreadyout_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d     = S_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = 4'd0;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                dphase_d    = 1'b0;
            end
        endcase
    end

    // Control and captured address phase; reset aborts any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            dphase_q    <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            idx_q       <= '0;
            lo_q        <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            dphase_q    <= dphase_d;
            write_q     <= write_d;
            size_q      <= size_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
        end
    end

    // Commit the strobed byte lanes at the edge that ends the write data phase.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is driven only in the completing cycle of a read, else zero.
    always_comb begin
        HRDATA = rd_en ? mem_q[idx_q] : 32'd0;
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with one wait state and
// one with none, sharing the bus; read expectations go through a scoreboard queue.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic        which;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;

    logic        hsel1, ready1, resp1;
    logic        hsel0, ready0, resp0;
    logic [31:0] rdata1, rdata0;
    logic        obs_ready, obs_resp;
    logic [31:0] obs_rdata;

    int          n_cmp;
    int          n_fail;
    logic [31:0] sb[$];

    assign hsel1     = hsel & ~which;
    assign hsel0     = hsel & which;
    assign obs_ready = which ? ready0 : ready1;
    assign obs_resp  = which ? resp0  : resp1;
    assign obs_rdata = which ? rdata0 : rdata1;

    ahb_lite_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HTRANS(htrans), .HREADY(ready1), .HWDATA(hwdata),
        .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1)
    );

    ahb_lite_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HTRANS(htrans), .HREADY(ready0), .HWDATA(hwdata),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_read(input string tag);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected <empty scoreboard>", tag, obs_rdata);
        end else begin
            exp = sb.pop_front();
            check(tag, obs_rdata, exp);
        end
    endtask

    // One non-pipelined transfer: address phase, then data phase until ready.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata, input int exp_waits);
        int waits;
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        tick();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = wdata;
        waits  = 0;
        while (obs_ready !== 1'b1 && waits < 20) begin
            if (!wr) check({tag, "_rdata_wait"}, obs_rdata, 32'd0);
            waits++;
            tick();
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_resp"}, {31'd0, obs_resp}, 32'd0);
        if (!wr) check_read({tag, "_rdata"});
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        which  = 1'b0;
        hsel   = 1'b0;
        haddr  = 32'd0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_IDLE;
        hwdata = 32'd0;
        tick();
        tick();
        check("rst_ready", {31'd0, obs_ready}, 32'd1);
        check("rst_resp",  {31'd0, obs_resp},  32'd0);
        check("rst_rdata", obs_rdata, 32'd0);
        check("rst_state", 32'(u_dut1.state_q), 32'(S_IDLE));
        rst_n = 1'b1;
        tick();

        // One wait state: word write then read back.
        xfer("wr_dead", 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 1);
        sb.push_back(32'hDEADBEEF);
        xfer("rd_dead", 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1);

        // Byte lane 3 over a known word.
        xfer("wr_base", 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, 1);
        xfer("wr_byte", 1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000, 1);
        sb.push_back(32'hAA223344);
        xfer("rd_byte", 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1);

        // Upper half-word over a known word.
        xfer("wr_base2", 1'b1, 32'h14, HSIZE_WORD, 32'h11111111, 1);
        xfer("wr_half",  1'b1, 32'h16, HSIZE_HALF, 32'h5A5A0000, 1);
        sb.push_back(32'h5A5A1111);
        xfer("rd_half",  1'b0, 32'h14, HSIZE_WORD, 32'h0, 1);

        // IDLE with HSEL=1: zero-wait OKAY, no memory access.
        hsel   = 1'b1;
        htrans = HTRANS_IDLE;
        haddr  = 32'h10;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        tick();
        hsel   = 1'b0;
        hwrite = 1'b0;
        hwdata = 32'hFFFFFFFF;
        check("idle_ready", {31'd0, obs_ready}, 32'd1);
        check("idle_resp",  {31'd0, obs_resp},  32'd0);
        check("idle_rdata", obs_rdata, 32'd0);
        tick();
        sb.push_back(32'hAA223344);
        xfer("rd_after_idle", 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1);

        // Reset pulsed while a write sits in its wait state.
        xfer("wr_pre_rst", 1'b1, 32'h40, HSIZE_WORD, 32'h55555555, 1);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = 32'h40;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        tick();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = 32'h12345678;
        check("mid_wait_ready", {31'd0, obs_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        check("rst_mid_ready", {31'd0, obs_ready}, 32'd1);
        check("rst_mid_resp",  {31'd0, obs_resp},  32'd0);
        check("rst_mid_state", 32'(u_dut1.state_q), 32'(S_IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        sb.push_back(32'h55555555);
        xfer("rd_post_rst", 1'b0, 32'h40, HSIZE_WORD, 32'h0, 1);

`ifdef AHB_SRAM_ERR_EN
        // Out-of-range write: two-cycle ERROR, memory untouched.
        xfer("wr_w0", 1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, 1);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = 32'h400;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        tick();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = 32'hFFFFFFFF;
        check("err1_ready", {31'd0, obs_ready}, 32'd0);
        check("err1_resp",  {31'd0, obs_resp},  32'd1);
        tick();
        check("err2_ready", {31'd0, obs_ready}, 32'd1);
        check("err2_resp",  {31'd0, obs_resp},  32'd1);
        tick();
        check("err_done_ready", {31'd0, obs_ready}, 32'd1);
        check("err_done_resp",  {31'd0, obs_resp},  32'd0);
        sb.push_back(32'hCAFEF00D);
        xfer("rd_w0_err", 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1);
`else
        // Out-of-range write wraps onto word 0; misaligned half masks lanes 1..2.
        xfer("wr_w0",   1'b1, 32'h0,   HSIZE_WORD, 32'hCAFEF00D, 1);
        xfer("wr_wrap", 1'b1, 32'h400, HSIZE_WORD, 32'h01020304, 1);
        sb.push_back(32'h01020304);
        xfer("rd_wrap", 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1);
        xfer("wr_mis",  1'b1, 32'h1, HSIZE_HALF, 32'hAABBCCDD, 1);
        sb.push_back(32'h01BBCC04);
        xfer("rd_mis",  1'b0, 32'h0, HSIZE_WORD, 32'h0, 1);
`endif

        // Zero wait states: back-to-back write then read of the same word.
        which  = 1'b1;
        tick();
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = 32'h20;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        tick();
        hwdata = 32'h5;
        hwrite = 1'b0;
        check("b2b_wr_ready", {31'd0, obs_ready}, 32'd1);
        check("b2b_wr_resp",  {31'd0, obs_resp},  32'd0);
        sb.push_back(32'h5);
        tick();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        check("b2b_rd_ready", {31'd0, obs_ready}, 32'd1);
        check("b2b_rd_resp",  {31'd0, obs_resp},  32'd0);
        check_read("b2b_rd_rdata");
        tick();
        sb.push_back(32'h5);
        xfer("rd0_again", 1'b0, 32'h20, HSIZE_WORD, 32'h0, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
